// File: rtl/score_pkg.sv
// Shared encodings for the 3-digit multiplexed seven-segment score bus.
// Segment bit order is {top, top_right, bot_right, bot, bot_left, top_left, middle}.
package score_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Cathode triple ordered {cathode_1, cathode_2, cathode_3}, active-low.
  typedef enum logic [2:0] {
    SelHundreds = 3'b011,
    SelTens     = 3'b101,
    SelOnes     = 3'b110,
    SelIdle     = 3'b111
  } digit_sel_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } slot_t;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational seven-segment to BCD digit decoder; anything outside 0..9 is invalid.
module seg7_to_digit
  import score_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       valid_o
);

  always_comb begin
    digit_o = 4'd0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/score_decoder.sv
// Receiver for the multiplexed 3-digit score display: captures each digit from the
// cathode scan, assembles frames and publishes the value once it has been stable.
module score_decoder
  import score_pkg::*;
#(
  parameter int unsigned SEG_LAG       = 1,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cathode_1,
  input  logic       cathode_2,
  input  logic       cathode_3,
  input  logic [6:0] seg,
  output logic [9:0] number,
  output logic       number_valid,
  output logic       changed,
  output logic       seg_error
);

  localparam int unsigned    Stages    = (SEG_LAG == 0) ? 1 : SEG_LAG;
  localparam int unsigned    ToW       = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToMax     = ToW'(TIMEOUT);
  localparam logic [ToW-1:0] ToOne     = ToW'(1);
  localparam logic [3:0]     StableMax = 4'(STABLE_FRAMES);

  logic [2:0]     cath_raw, cath_al;
  logic [2:0]     dly_q [Stages];
  logic [2:0]     dly_d [Stages];
  slot_t          slot_q [3];
  slot_t          slot_d [3];
  logic [2:0]     mask_q, mask_d;
  logic [3:0]     stab_q, stab_d;
  logic [9:0]     prev_q, prev_d;
  logic [ToW-1:0] to_q, to_d;
  logic [9:0]     number_q, number_d;
  logic           valid_q, valid_d;
  logic           changed_q, changed_d;
  logic           err_q, err_d;

  logic [3:0]     dec_digit;
  logic           dec_valid;
  logic [2:0]     sel;
  logic           proto_err;
  logic           complete;
  logic           all_valid;
  logic [9:0]     cand;

  seg7_to_digit u_dec (
    .seg_i   (seg),
    .digit_o (dec_digit),
    .valid_o (dec_valid)
  );

  assign cath_raw = {cathode_1, cathode_2, cathode_3};

  always_comb begin
    dly_d[0] = cath_raw;
    for (int unsigned i = 1; i < Stages; i++) dly_d[i] = dly_q[i-1];
  end

  assign cath_al   = (SEG_LAG == 0) ? cath_raw : dly_q[Stages-1];
  assign complete  = (mask_q == 3'b111);
  assign all_valid = slot_q[0].valid & slot_q[1].valid & slot_q[2].valid;
  assign cand      = 10'(slot_q[2].digit) * 10'd100 + 10'(slot_q[1].digit) * 10'd10
                   + 10'(slot_q[0].digit);

  always_comb begin
    slot_d    = slot_q;
    mask_d    = mask_q;
    stab_d    = stab_q;
    prev_d    = prev_q;
    to_d      = to_q;
    number_d  = number_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    err_d     = 1'b0;
    sel       = 3'b000;
    proto_err = 1'b0;

    case (cath_al)
      SelIdle:     sel = 3'b000;
      SelHundreds: sel = 3'b100;
      SelTens:     sel = 3'b010;
      SelOnes:     sel = 3'b001;
      default:     proto_err = 1'b1;
    endcase

    if (complete) begin
      mask_d = 3'b000;
      to_d   = '0;
      // A scan collision in the evaluation cycle also voids the frame, so that
      // seg_error and changed stay mutually exclusive.
      if (proto_err || !all_valid) begin
        err_d  = 1'b1;
        stab_d = 4'd0;
      end else begin
        if (cand == prev_q) begin
          stab_d = (stab_q == StableMax) ? StableMax : stab_q + 4'd1;
        end else begin
          stab_d = 4'd1;
          prev_d = cand;
        end
        if (stab_d == StableMax) begin
          number_d  = cand;
          valid_d   = 1'b1;
          changed_d = (cand != number_q) || !valid_q;
        end
      end
    end else begin
      if (to_q != ToMax) to_d = to_q + ToOne;
      if (to_q == ToMax - ToOne) begin
        valid_d = 1'b0;
        stab_d  = 4'd0;
      end
    end

    if (proto_err) begin
      err_d  = 1'b1;
      mask_d = 3'b000;
      slot_d = '{default: '0};
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sel[i]) begin
          slot_d[i] = '{valid: dec_valid, digit: dec_digit};
          mask_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly_q     <= '{default: 3'b111};
      slot_q    <= '{default: '0};
      mask_q    <= 3'b000;
      stab_q    <= 4'd0;
      prev_q    <= 10'd0;
      to_q      <= '0;
      number_q  <= 10'd0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      slot_q    <= slot_d;
      mask_q    <= mask_d;
      stab_q    <= stab_d;
      prev_q    <= prev_d;
      to_q      <= to_d;
      number_q  <= number_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign changed      = changed_q;
  assign seg_error    = err_q;

endmodule

// File: doc/score_decoder.md
Name: score_decoder

Overview:
- Receiver for the 3-digit multiplexed seven-segment score bus (three active-low cathodes plus seven active-high segments).
- Watches the cathode scan, decodes the segment pattern for each digit and assembles a hundreds/tens/ones frame.
- Publishes the number once it has been stable for several frames.
- Used for on-board loopback checking of the score display path and for feeding the displayed score back to the game controller.

Parameters:
- SEG_LAG, 1: cycles by which the segment inputs trail the cathode pattern they belong to (0..3).
- STABLE_FRAMES, 2: consecutive identical complete frames required before publishing (1..15).
- TIMEOUT, 1024: cycles without a completed frame before number_valid drops (must be at least 8).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cathode_1  input  1  active-low select, hundreds digit
- cathode_2  input  1  active-low select, tens digit
- cathode_3  input  1  active-low select, ones digit
- seg  input  7  {top, top_right, bot_right, bot, bot_left, top_left, middle}, active-high
- number  output  10  last published value, 0..999
- number_valid  output  1  number is current (not timed out)
- changed  output  1  one-cycle pulse when a published value differs from the previous one
- seg_error  output  1  one-cycle pulse on a protocol or decode error

Behaviour:
- Reset (asynchronous, active-high) clears:
  - outputs: number=0, number_valid=0, changed=0, seg_error=0;
  - internal state: digit slots, captured mask, stability counter, timeout counter, cathode delay line (cleared to 3'b111).
- Alignment:
  - The cathode triple goes through a SEG_LAG-stage register chain.
  - seg is paired with the delayed triple of the same cycle. SEG_LAG=0 means no delay.
- Per-cycle classification of the delayed triple:
  - 3'b111 (idle): ignored.
  - Exactly one low: sample seg into that digit's slot and set its bit in the 3-bit captured mask. A later sample of an already-captured digit overwrites the slot.
  - Two or more low: seg_error pulse; captured mask and slots cleared.
- Segment decode table (0..9 only):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other pattern, including blank 0000000, marks that slot invalid.
- Frame completion (captured mask reaches 3'b111), evaluated the cycle after the completing sample:
  - Any slot invalid: seg_error pulse, frame discarded, stability counter cleared.
  - Otherwise candidate = h*100 + t*10 + o, computed in 10 bits with no overflow (max 999).
  - Candidate equals the previous candidate: stability counter increments, saturating at STABLE_FRAMES. Otherwise it is set to 1 and the previous candidate is updated.
  - When the counter reaches STABLE_FRAMES: number <= candidate, number_valid <= 1. changed pulses if the candidate differs from the old number or number_valid was 0.
  - Mask cleared after every completion, good or bad.
- Timeout:
  - The counter resets on every completed frame, good or bad.
  - On reaching TIMEOUT: number_valid <= 0, stability counter cleared. number holds its value.
- Latency: number updates 2 cycles after the sample that completes the qualifying frame (1 cycle to evaluate, 1 cycle to register).
- Simultaneous events: a timeout and a completion in the same cycle resolve in favour of the completion. seg_error and changed never assert in the same cycle.
- Reset mid-frame discards the partial frame and any pending publish.

Decomposition:
- Shared package score_pkg holds:
  - the seven-bit segment encodings SEG_0..SEG_9 and SEG_BLANK, in the bit order above;
  - the digit-select encodings for cathodes.
  A future encoder side and this block both use them.
- One sub-module, seg7_to_digit: combinational; seg in, 4-bit digit plus valid out.

Test Plan:
- Scan 3/7/5 with SEG_LAG=1, STABLE_FRAMES=2, three frames → number=375 and number_valid=1 after the second complete frame; one changed pulse.
- Steady 375, then scan changes to 376 → no update after the first 376 frame; number=376 plus a changed pulse after the second.
- Tens slot driven with 0000000 (blank) for one frame → seg_error pulse; number stays 375; stability restarts.
- cathode_1 and cathode_2 both low for one cycle mid-frame → seg_error pulse; partial frame discarded; the next clean frames republish normally.
- Cathodes held 3'b111 for TIMEOUT cycles → number_valid=0, number=375 held; two good frames of 375 → number_valid=1 with a changed pulse.
- Reset asserted asynchronously mid-frame → all outputs 0 immediately; first publish needs STABLE_FRAMES fresh frames (value 999 checks width).
